// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - Q-format constants and size derivations shared by the convolution accumulators
package conv_pkg;

    localparam int Q_DATA_WIDTH = 32;
    localparam int Q_FRAC_BITS  = 16;

    // Largest signed value representable in a word of the given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest signed value representable in a word of the given width.
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Products summed into one output point.
    function automatic int calc_acc_len(input int channels, input int kernel);
        return channels * kernel * kernel;
    endfunction

    // Counter width with one spare bit so ACC_LEN itself is representable.
    function automatic int calc_cnt_width(input int acc_len);
        return $clog2(acc_len) + 1;
    endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// rtl/conv_sat_shift.sv - arithmetic rescale of a wide accumulator and saturation to one data word
module conv_sat_shift
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = Q_DATA_WIDTH,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int ACC_WIDTH  = 2 * Q_DATA_WIDTH + 5
) (
    input  logic signed [ACC_WIDTH-1:0]  sum_in,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] shifted;

    // Drop the fractional bits (floor toward -inf) and clamp into the output range.
    always_comb begin
        shifted = sum_in >>> FRAC_BITS;
        if (shifted > MAX_V) begin
            data_out = MAX_V[DATA_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            data_out = MIN_V[DATA_WIDTH-1:0];
        end else begin
            data_out = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_channel_accum.sv
// rtl/conv_channel_accum.sv - pipelined multiply-accumulate of one kernel window plus bias, rescaled and saturated
module conv_channel_accum
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = Q_DATA_WIDTH,
    parameter int FRAC_BITS      = Q_FRAC_BITS,
    parameter int CHANNEL_NUM_IN = 1,
    parameter int KERNEL_SIZE    = 3,
    parameter int ACC_LEN        = calc_acc_len(CHANNEL_NUM_IN, KERNEL_SIZE),
    parameter int CNT_WIDTH      = calc_cnt_width(ACC_LEN),
    parameter int ACC_WIDTH      = 2 * DATA_WIDTH + CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         busy
);

    localparam int                   PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(ACC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    // S1: product register, input-side group counter, bias of the group being fed in
    logic [CNT_WIDTH-1:0]         in_cnt_q, in_cnt_d;
    logic signed [PROD_WIDTH-1:0] prod_q, prod_d;
    logic                         prod_v_q, prod_v_d;
    logic signed [DATA_WIDTH-1:0] bias_r_q, bias_r_d;

    // S2: accumulator, product counter, bias travelling alongside the accumulator
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] bias_acc_q, bias_acc_d;
    logic                         done_v_q, done_v_d;

    // S3: registered result
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         valid_out_q, valid_out_d;

    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] sat_result;

    // S1: multiply each accepted pair; latch the bias on the first element of a group.
    always_comb begin
        in_cnt_d = in_cnt_q;
        prod_d   = prod_q;
        prod_v_d = 1'b0;
        bias_r_d = bias_r_q;
        if (clear) begin
            in_cnt_d = '0;
        end else if (valid_in) begin
            prod_d   = PROD_WIDTH'(data_in) * PROD_WIDTH'(weight_in);
            prod_v_d = 1'b1;
            if (in_cnt_q == '0) begin
                bias_r_d = bias_in;
            end
            in_cnt_d = (in_cnt_q == CNT_LAST) ? '0 : in_cnt_q + CNT_ONE;
        end
    end

    // S2: restart or extend the running sum; flag the group's final product.
    // The bias is moved here with the first product so the next group's S1
    // capture cannot overwrite it before S3 uses it.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        bias_acc_d = bias_acc_q;
        done_v_d   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (prod_v_q) begin
            if (cnt_q == '0) begin
                acc_d      = ACC_WIDTH'(prod_q);
                bias_acc_d = bias_r_q;
            end else begin
                acc_d = acc_q + ACC_WIDTH'(prod_q);
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                done_v_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign bias_ext = ACC_WIDTH'(bias_acc_q) <<< FRAC_BITS;
    assign sum      = acc_q + bias_ext;

    conv_sat_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_shift (
        .sum_in   (sum),
        .data_out (sat_result)
    );

    // S3: register the saturated result for a completed group; hold it otherwise.
    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = done_v_q;
        if (done_v_q) begin
            data_out_d = sat_result;
        end
    end

    // Pipeline state; reset discards any partial group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_q    <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            bias_r_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            bias_acc_q  <= '0;
            done_v_q    <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            bias_r_q    <= bias_r_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bias_acc_q  <= bias_acc_d;
            done_v_q    <= done_v_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign busy      = (cnt_q != '0) || prod_v_q;

endmodule

// File: tb/tb_conv_channel_accum.sv
// tb/tb_conv_channel_accum.sv - randomized bench for conv_channel_accum against a group-sum reference model
module tb_conv_channel_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear0, valid0, clear1, valid1;
    logic [31:0] data0, weight0, bias0, data1, weight1, bias1;
    logic [31:0] data_out0, data_out1;
    logic        valid_out0, valid_out1, busy0, busy1;

    conv_channel_accum u_dut9 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear0),
        .valid_in  (valid0),
        .data_in   (data0),
        .weight_in (weight0),
        .bias_in   (bias0),
        .data_out  (data_out0),
        .valid_out (valid_out0),
        .busy      (busy0)
    );

    conv_channel_accum #(.KERNEL_SIZE(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear1),
        .valid_in  (valid1),
        .data_in   (data1),
        .weight_in (weight1),
        .bias_in   (bias1),
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .busy      (busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          at;
        logic [31:0] val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: one running exact sum per DUT, expressed as real-number arithmetic.
    int                  m_len[2] = '{9, 1};
    int                  m_cnt[2] = '{0, 0};
    logic signed [127:0] m_sum[2];
    logic signed [31:0]  m_bias[2];

    function automatic logic [31:0] ref_result(input logic signed [127:0] s, input logic signed [31:0] b);
        logic signed [127:0] t;
        logic signed [127:0] q;
        logic signed [127:0] bb;
        bb = b;
        t  = s + bb * 128'sd65536;
        q  = t / 128'sd65536;
        if (t < 0 && q * 128'sd65536 != t) q = q - 128'sd1;
        if (q > 128'sd2147483647) q = 128'sd2147483647;
        if (q < -128'sd2147483648) q = -128'sd2147483648;
        return q[31:0];
    endfunction

    task automatic model_in(input int u, input logic clr, input logic v,
                            input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
        longint p;
        exp_t   e;
        if (clr) begin
            m_cnt[u] = 0;
        end else if (v) begin
            if (m_cnt[u] == 0) begin
                m_sum[u]  = '0;
                m_bias[u] = b;
            end
            p        = $signed(d) * $signed(w);
            m_sum[u] = m_sum[u] + p;
            m_cnt[u] = m_cnt[u] + 1;
            if (m_cnt[u] == m_len[u]) begin
                m_cnt[u] = 0;
                e.at  = cyc + 3;
                e.val = ref_result(m_sum[u], m_bias[u]);
                if (u == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Compare every output pulse (and every cycle a pulse is due) against the model queue.
    always @(negedge clk) begin
        logic exp_v0;
        if (reset) begin
            if (q0.size() > 0 && q0[0].at < cyc) begin
                check("missed_pulse9", 32'd0, 32'd1);
                void'(q0.pop_front());
            end
            exp_v0 = (q0.size() > 0 && q0[0].at == cyc);
            if (exp_v0 || valid_out0) begin
                check("valid_out9", {31'd0, valid_out0}, {31'd0, exp_v0});
                if (exp_v0) begin
                    check("data_out9", data_out0, q0[0].val);
                    void'(q0.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_v1;
        if (reset) begin
            if (q1.size() > 0 && q1[0].at < cyc) begin
                check("missed_pulse1", 32'd0, 32'd1);
                void'(q1.pop_front());
            end
            exp_v1 = (q1.size() > 0 && q1[0].at == cyc);
            if (exp_v1 || valid_out1) begin
                check("valid_out1", {31'd0, valid_out1}, {31'd0, exp_v1});
                if (exp_v1) begin
                    check("data_out1", data_out1, q1[0].val);
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic step(input int u, input logic v, input logic clr,
                        input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
        if (u == 0) begin
            valid0 = v; clear0 = clr; data0 = d; weight0 = w; bias0 = b;
        end else begin
            valid1 = v; clear1 = clr; data1 = d; weight1 = w; bias1 = b;
        end
        model_in(u, clr, v, d, w, b);
        @(posedge clk);
        #1;
        valid0 = 1'b0; clear0 = 1'b0;
        valid1 = 1'b0; clear1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            idle(1);
        end
        check("drain", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        m_cnt = '{0, 0};
        q0.delete();
        q1.delete();
        idle(n);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = {{12{r[19]}}, r[19:0]};
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        clear0 = 1'b0; valid0 = 1'b0; data0 = '0; weight0 = '0; bias0 = '0;
        clear1 = 1'b0; valid1 = 1'b0; data1 = '0; weight1 = '0; bias1 = '0;
        m_sum  = '{128'sd0, 128'sd0};
        m_bias = '{32'sd0, 32'sd0};
        idle(3);
        check("reset_data_out9", data_out0, 32'd0);
        check("reset_valid_out9", {31'd0, valid_out0}, 32'd0);
        check("reset_busy9", {31'd0, busy0}, 32'd0);
        check("reset_data_out1", data_out1, 32'd0);
        check("reset_valid_out1", {31'd0, valid_out1}, 32'd0);
        check("reset_busy1", {31'd0, busy1}, 32'd0);
        reset = 1'b1;
        idle(1);

        // 9 x (1.0 * 0.5) = 4.5
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h00010000, 32'h00008000, 32'h0);
        drain();
        check("basic_value", data_out0, 32'h00048000);
        idle(4);
        check("basic_hold", data_out0, 32'h00048000);
        check("basic_busy_idle", {31'd0, busy0}, 32'd0);

        // single-product groups: floor of a negative and bias addition
        step(1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0);
        drain();
        check("neg_trunc", data_out1, 32'hFFFFFFFF);
        step(1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00010000);
        drain();
        check("bias_add", data_out1, 32'h0000FFFF);

        // saturation in both directions
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h7FFF0000, 32'h00020000, 32'h0);
        drain();
        check("sat_pos", data_out0, 32'h7FFFFFFF);
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h7FFF0000, 32'hFFFE0000, 32'h0);
        drain();
        check("sat_neg", data_out0, 32'h80000000);

        // group A with gaps, then group B with no gap
        for (int i = 0; i < 9; i++) begin
            step(0, 1'b1, 1'b0, rand_word(), rand_word(), rand_word());
            if (i == 4) check("busy_mid_a", {31'd0, busy0}, 32'd1);
            if (i < 8) idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, rand_word(), rand_word(), rand_word());
        check("busy_end_b", {31'd0, busy0}, 32'd1);
        drain();
        check("busy_after_b", {31'd0, busy0}, 32'd0);

        // reset in the middle of a group discards it
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 32'h00030000, 32'h00020000, 32'h00050000);
        apply_reset(2);
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h0);
        drain();
        check("after_reset", data_out0, 32'h00090000);

        // clear together with a valid input aborts the group and drops that input
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 32'h00020000, 32'h00020000, 32'h00010000);
        step(0, 1'b1, 1'b1, 32'h00040000, 32'h00040000, 32'h00070000);
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h0);
        drain();
        check("after_clear", data_out0, 32'h00090000);

        // random groups, random gaps, both configurations
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 9; i++) begin
                step(0, 1'b1, 1'b0, rand_word(), rand_word(), rand_word());
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1'b1, 1'b0, rand_word(), rand_word(), rand_word());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        drain();
        check("final_busy9", {31'd0, busy0}, 32'd0);
        check("final_busy1", {31'd0, busy1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
